serial_deser_align: RTL

Soft serial-to-parallel receiver: the input-side counterpart to the OSERDESE3 serializer test path. It samples one serial bit per clk on di, assembles DATA_WIDTH-bit words MSB-first, and emits each word with a one-cycle valid strobe. A word-alignment FSM bit-slips the word boundary until a programmable sync word is seen LOCK_COUNT consecutive times. It sits between a serial pin/fabric stream and the capture shift registers in the minitest harness.

---
 rtl/serial_deser_align.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/serial_deser_align.sv
// serial_deser_align: soft serial-to-parallel receiver with bit-slip word alignment.
// Bits arrive MSB-first, one per clk, and are packed into DATA_WIDTH-bit words that
// are presented with a one-cycle valid strobe. An alignment FSM slips the word
// boundary one bit later at a time until SYNC_WORD has been seen LOCK_COUNT times
// in a row. It gives up with a sticky error after 2*DATA_WIDTH slips.

module serial_deser_align #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SYNC_WORD  = 8'hB8,
  parameter int         LOCK_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          di,
  input  logic                          align_req,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          locked,
  output logic [$clog2(DATA_WIDTH)-1:0] slip_count,
  output logic                          err
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int ATT_W = $clog2(2 * DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ATT_W-1:0]      ATT_LIMIT    = ATT_W'(2 * DATA_WIDTH);
  localparam logic [3:0]            MATCH_TARGET = 4'(LOCK_COUNT);
  localparam logic [DATA_WIDTH-1:0] SYNC         = SYNC_WORD[DATA_WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    CONFIRM,
    LOCKED
  } stateT;

  stateT r_state;
  stateT w_stateNext;

  // Only the newest DATA_WIDTH-1 bits are stored; the current di completes the word.
  logic [DATA_WIDTH-2:0] r_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_doutValid;
  logic                  r_locked;
  logic [CNT_W-1:0]      r_slipCount;
  logic                  r_err;
  logic [3:0]            r_matchCnt;
  logic [ATT_W-1:0]      r_attempt;
  logic                  r_slipPending;

  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_boundary;
  logic                  w_slipNow;
  logic                  w_emit;
  logic                  w_isSync;
  logic [3:0]            w_matchInc;
  logic [ATT_W-1:0]      w_attemptInc;
  logic [CNT_W-1:0]      w_cntNext;
  logic [CNT_W-1:0]      w_slipCountNext;
  logic                  w_errNext;
  logic [3:0]            w_matchCntNext;
  logic [ATT_W-1:0]      w_attemptNext;
  logic                  w_slipPendingNext;

  // Candidate word and boundary decode. An align request cancels a slip that would
  // otherwise be consumed at this boundary, so the boundary emits normally instead.
  assign w_word       = {r_sr, di};
  assign w_boundary   = (r_cnt == CNT_LAST);
  assign w_slipNow    = w_boundary && r_slipPending && !align_req;
  assign w_emit       = w_boundary && !w_slipNow;
  assign w_isSync     = (w_word == SYNC);
  assign w_matchInc   = r_matchCnt + 4'd1;
  assign w_attemptInc = r_attempt + 1'b1;

  // A slip holds the counter on its last value so the next cycle is a boundary again,
  // which moves the word window one bit later.
  assign w_cntNext = w_slipNow  ? r_cnt :
                     w_boundary ? '0    :
                                  r_cnt + 1'b1;

  // Next-state and alignment bookkeeping; align requests win over slips and compares.
  always_comb begin
    w_stateNext       = r_state;
    w_slipCountNext   = r_slipCount;
    w_errNext         = r_err;
    w_matchCntNext    = r_matchCnt;
    w_attemptNext     = r_attempt;
    w_slipPendingNext = r_slipPending;

    if (align_req) begin
      w_stateNext       = SEARCH;
      w_slipCountNext   = '0;
      w_errNext         = 1'b0;
      w_matchCntNext    = '0;
      w_attemptNext     = '0;
      w_slipPendingNext = 1'b0;
    end else if (w_slipNow) begin
      w_slipPendingNext = 1'b0;
      w_slipCountNext   = r_slipCount + 1'b1;
      w_attemptNext     = w_attemptInc;
      if (w_attemptInc == ATT_LIMIT) begin
        w_errNext   = 1'b1;
        w_stateNext = IDLE;
      end
    end else if (w_emit) begin
      case (r_state)
        IDLE: begin
        end
        SEARCH: begin
          if (w_isSync) begin
            w_matchCntNext = 4'd1;
            w_stateNext    = (MATCH_TARGET == 4'd1) ? LOCKED : CONFIRM;
          end else begin
            w_slipPendingNext = 1'b1;
          end
        end
        CONFIRM: begin
          if (w_isSync) begin
            w_matchCntNext = w_matchInc;
            if (w_matchInc == MATCH_TARGET) begin
              w_stateNext = LOCKED;
            end
          end else begin
            w_matchCntNext    = '0;
            w_stateNext       = SEARCH;
            w_slipPendingNext = 1'b1;
          end
        end
        LOCKED: begin
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // Alignment FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Shift register, word assembly, output strobe and alignment counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr          <= '0;
      r_cnt         <= '0;
      r_dout        <= '0;
      r_doutValid   <= 1'b0;
      r_locked      <= 1'b0;
      r_slipCount   <= '0;
      r_err         <= 1'b0;
      r_matchCnt    <= '0;
      r_attempt     <= '0;
      r_slipPending <= 1'b0;
    end else begin
      r_sr        <= w_word[DATA_WIDTH-2:0];
      r_cnt       <= w_cntNext;
      r_doutValid <= w_emit;
      if (w_emit) begin
        r_dout <= w_word;
      end
      r_locked      <= (w_stateNext == LOCKED);
      r_slipCount   <= w_slipCountNext;
      r_err         <= w_errNext;
      r_matchCnt    <= w_matchCntNext;
      r_attempt     <= w_attemptNext;
      r_slipPending <= w_slipPendingNext;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_doutValid;
  assign locked     = r_locked;
  assign slip_count = r_slipCount;
  assign err        = r_err;

endmodule
